// File: rtl/aip_slave_hub.sv
// aip_slave_hub
// Connects one upstream AIP master port to NUM_SLAVES AIP slave channels.
// Write data and config codes are broadcast to every slave. The write, read
// and start strobes go only to the selected slave. A small block of hub
// registers sits at the top of the config code space. It holds the slave
// select, the interrupt mask, the pending interrupts, a status word and a
// round-robin "next pending" service port.
//
// Ports
//   i_clk, i_rst_a          clock, async active-high reset
//   i_data_in / o_data_out  upstream write / read data (read is 1-cycle registered)
//   i_write/i_read/i_start  upstream strobes
//   i_conf_dbus             upstream config code (hub register or pass-through)
//   o_int_req               registered OR of pending & mask
//   o_dataIn_s, o_config_s  broadcast per-slave write data / config, slice k = slave k
//   o_write_s/o_read_s/o_start_s  per-slave strobes, only bit [sel] can be set
//   i_dataOut_s             per-slave read data, slice k = slave k
//   i_int_s                 per-slave interrupt levels (rising edge = request)
module aip_slave_hub #(
    parameter int NUM_SLAVES = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CONF_WIDTH = 5
) (
    input  logic                             i_clk,
    input  logic                             i_rst_a,
    input  logic [DATA_WIDTH-1:0]            i_data_in,
    output logic [DATA_WIDTH-1:0]            o_data_out,
    input  logic                             i_write,
    input  logic                             i_read,
    input  logic                             i_start,
    input  logic [CONF_WIDTH-1:0]            i_conf_dbus,
    output logic                             o_int_req,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] o_dataIn_s,
    output logic [NUM_SLAVES*CONF_WIDTH-1:0] o_config_s,
    output logic [NUM_SLAVES-1:0]            o_write_s,
    output logic [NUM_SLAVES-1:0]            o_read_s,
    output logic [NUM_SLAVES-1:0]            o_start_s,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_dataOut_s,
    input  logic [NUM_SLAVES-1:0]            i_int_s
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    localparam logic [CONF_WIDTH-1:0] ADDR_SEL    = CONF_WIDTH'(5'h1F);
    localparam logic [CONF_WIDTH-1:0] ADDR_MASK   = CONF_WIDTH'(5'h1E);
    localparam logic [CONF_WIDTH-1:0] ADDR_PEND   = CONF_WIDTH'(5'h1D);
    localparam logic [CONF_WIDTH-1:0] ADDR_STATUS = CONF_WIDTH'(5'h1C);
    localparam logic [CONF_WIDTH-1:0] ADDR_NEXT   = CONF_WIDTH'(5'h1B);

    logic [SEL_W-1:0]      sel;
    logic [SEL_W-1:0]      last_served;
    logic [NUM_SLAVES-1:0] mask;
    logic [NUM_SLAVES-1:0] pend;
    logic [NUM_SLAVES-1:0] int_prev;
    logic                  sel_err;
    logic                  primed;
    logic                  read_d;

    logic                  is_hub;
    logic                  wr_hub;
    logic                  sel_wr;
    logic                  sel_ok;
    logic                  next_fire;
    logic                  next_hit;
    logic [SEL_W-1:0]      next_idx;
    logic [NUM_SLAVES-1:0] next_clr;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic [NUM_SLAVES-1:0] pend_masked;
    logic [NUM_SLAVES-1:0] int_edge;
    logic [NUM_SLAVES-1:0] w1c;
    logic [NUM_SLAVES-1:0] pend_nxt;
    logic [DATA_WIDTH-1:0] rd_slice;
    logic [DATA_WIDTH-1:0] hub_val;
    int                    cand;

    assign is_hub = (i_conf_dbus == ADDR_SEL)  || (i_conf_dbus == ADDR_MASK) ||
                    (i_conf_dbus == ADDR_PEND) || (i_conf_dbus == ADDR_STATUS) ||
                    (i_conf_dbus == ADDR_NEXT);
    assign wr_hub = i_write && is_hub;
    assign sel_wr = wr_hub && (i_conf_dbus == ADDR_SEL);
    assign sel_ok = i_data_in < DATA_WIDTH'(NUM_SLAVES);

    // NEXT acts only on the first cycle of a read, so a long read strobe
    // does not drain several pending interrupts.
    assign next_fire = i_read && !read_d && (i_conf_dbus == ADDR_NEXT);

    // Edge history is cleared by reset. The first cycle after release only
    // loads it, so lines that are already high do not raise requests.
    assign int_edge    = primed ? (i_int_s & ~int_prev) : '0;
    assign pend_masked = pend & mask;
    assign w1c         = (wr_hub && (i_conf_dbus == ADDR_PEND)) ? i_data_in[NUM_SLAVES-1:0] : '0;
    // A new edge wins over a clear in the same cycle.
    assign pend_nxt    = (pend & ~w1c & ~next_clr) | int_edge;

    always_comb begin
        sel_onehot = '0;
        rd_slice   = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (SEL_W'(k) == sel) begin
                sel_onehot[k] = 1'b1;
                rd_slice      = i_dataOut_s[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin search starting one past the last served slave.
    always_comb begin
        next_hit = 1'b0;
        next_idx = '0;
        cand     = 0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            cand = (int'(last_served) + 1 + i) % NUM_SLAVES;
            if (!next_hit && pend_masked[cand]) begin
                next_hit = 1'b1;
                next_idx = SEL_W'(cand);
            end
        end
    end

    always_comb begin
        next_clr = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (next_fire && next_hit && (SEL_W'(k) == next_idx)) begin
                next_clr[k] = 1'b1;
            end
        end
    end

    always_comb begin
        hub_val = '0;
        case (i_conf_dbus)
            ADDR_SEL:    hub_val[SEL_W-1:0] = sel;
            ADDR_MASK:   hub_val[NUM_SLAVES-1:0] = mask;
            ADDR_PEND:   hub_val[NUM_SLAVES-1:0] = pend;
            ADDR_STATUS: begin
                hub_val[SEL_W-1:0] = sel;
                hub_val[8]         = sel_err;
                hub_val[9]         = o_int_req;
            end
            ADDR_NEXT: begin
                if (next_hit) begin
                    hub_val[DATA_WIDTH-1] = 1'b1;
                    hub_val[SEL_W-1:0]    = next_idx;
                end
            end
            default: hub_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst_a) begin
        if (i_rst_a) begin
            sel         <= '0;
            last_served <= SEL_W'(NUM_SLAVES - 1);
            mask        <= '0;
            pend        <= '0;
            int_prev    <= '0;
            sel_err     <= 1'b0;
            primed      <= 1'b0;
            read_d      <= 1'b0;
            o_int_req   <= 1'b0;
            o_data_out  <= '0;
            o_write_s   <= '0;
            o_read_s    <= '0;
            o_start_s   <= '0;
            o_dataIn_s  <= '0;
            o_config_s  <= '0;
        end else begin
            read_d   <= i_read;
            int_prev <= i_int_s;
            primed   <= 1'b1;
            pend     <= pend_nxt;

            if (wr_hub && (i_conf_dbus == ADDR_MASK)) begin
                mask <= i_data_in[NUM_SLAVES-1:0];
            end

            if (sel_wr) begin
                if (sel_ok) begin
                    sel <= i_data_in[SEL_W-1:0];
                end else begin
                    sel_err <= 1'b1;
                end
            end else if (next_fire && next_hit) begin
                sel <= next_idx;
            end

            if (next_fire && next_hit) begin
                last_served <= next_idx;
            end

            if (wr_hub && (i_conf_dbus == ADDR_STATUS)) begin
                sel_err <= 1'b0;
            end

            o_int_req  <= |pend_masked;
            o_data_out <= is_hub ? hub_val : rd_slice;
            // Strobes are steered by the sel value before any same-cycle update.
            o_write_s  <= (i_write && !is_hub) ? sel_onehot : '0;
            o_read_s   <= (i_read && !is_hub) ? sel_onehot : '0;
            o_start_s  <= i_start ? sel_onehot : '0;
            o_dataIn_s <= {NUM_SLAVES{i_data_in}};
            o_config_s <= {NUM_SLAVES{i_conf_dbus}};
        end
    end

endmodule

// File: tb/tb_aip_slave_hub.sv
module tb_aip_slave_hub;

    localparam int NS = 8;
    localparam int DW = 32;
    localparam int CW = 5;

    logic          i_clk = 1'b0;
    logic          i_rst_a;
    logic [DW-1:0] i_data_in;
    logic [DW-1:0] o_data_out;
    logic          i_write, i_read, i_start;
    logic [CW-1:0] i_conf_dbus;
    logic          o_int_req;
    logic [NS*DW-1:0] o_dataIn_s;
    logic [NS*CW-1:0] o_config_s;
    logic [NS-1:0] o_write_s, o_read_s, o_start_s;
    logic [NS*DW-1:0] i_dataOut_s;
    logic [NS-1:0] i_int_s;

    int checks   = 0;
    int failures = 0;

    aip_slave_hub #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .CONF_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_a(i_rst_a),
        .i_data_in(i_data_in), .o_data_out(o_data_out),
        .i_write(i_write), .i_read(i_read), .i_start(i_start),
        .i_conf_dbus(i_conf_dbus), .o_int_req(o_int_req),
        .o_dataIn_s(o_dataIn_s), .o_config_s(o_config_s),
        .o_write_s(o_write_s), .o_read_s(o_read_s), .o_start_s(o_start_s),
        .i_dataOut_s(i_dataOut_s), .i_int_s(i_int_s)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic hub_write(input logic [CW-1:0] addr, input logic [DW-1:0] data);
        i_conf_dbus = addr;
        i_data_in   = data;
        i_write     = 1'b1;
        tick();
        i_write     = 1'b0;
        i_conf_dbus = '0;
        i_data_in   = '0;
    endtask

    // One-cycle read, then one idle cycle so the next read is a fresh edge.
    task automatic hub_read(input logic [CW-1:0] addr, output logic [DW-1:0] data);
        i_conf_dbus = addr;
        i_read      = 1'b1;
        tick();
        data        = o_data_out;
        i_read      = 1'b0;
        i_conf_dbus = '0;
        tick();
    endtask

    task automatic test_reset();
        logic [DW-1:0] rd;
        i_rst_a = 1'b1;
        i_data_in = '0; i_write = 0; i_read = 0; i_start = 0;
        i_conf_dbus = '0; i_int_s = '0;
        for (int k = 0; k < NS; k++) i_dataOut_s[k*DW +: DW] = 32'hD000_0000 + k;
        tick(); tick();
        checks++;
        if ({o_write_s, o_read_s, o_start_s, o_int_req} !== '0) begin
            failures++;
            $display("FAIL reset_strobes got=%h/%h/%h/%b exp=0", o_write_s, o_read_s, o_start_s, o_int_req);
        end
        checks++;
        if (o_data_out !== '0 || o_dataIn_s !== '0 || o_config_s !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", o_data_out);
        end
        i_rst_a = 1'b0;
        tick();
        hub_read(5'h1C, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h0); end
        hub_read(5'h1E, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_mask got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_passthrough();
        hub_write(5'h1F, 32'd3);
        checks++;
        if (o_write_s !== 8'h00) begin failures++; $display("FAIL hub_write_no_strobe got=%h exp=00", o_write_s); end
        i_conf_dbus = 5'h02; i_data_in = 32'hA5A5_A5A5; i_write = 1'b1;
        tick();
        i_write = 1'b0;
        checks++;
        if (o_write_s !== 8'h08 || o_read_s !== 8'h00 || o_start_s !== 8'h00) begin
            failures++;
            $display("FAIL pass_write got=%h/%h/%h exp=08/00/00", o_write_s, o_read_s, o_start_s);
        end
        checks++;
        if (o_config_s[3*CW +: CW] !== 5'h02 || o_dataIn_s[3*DW +: DW] !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL pass_slice3 got=%h/%h exp=02/a5a5a5a5", o_config_s[3*CW +: CW], o_dataIn_s[3*DW +: DW]);
        end
        checks++;
        if (o_dataIn_s[6*DW +: DW] !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL pass_broadcast got=%h exp=a5a5a5a5", o_dataIn_s[6*DW +: DW]);
        end
        tick();
        checks++;
        if (o_write_s !== 8'h00) begin failures++; $display("FAIL pass_write_drop got=%h exp=00", o_write_s); end
        i_read = 1'b1;
        tick();
        i_read = 1'b0;
        checks++;
        if (o_read_s !== 8'h08 || o_data_out !== 32'hD000_0003) begin
            failures++;
            $display("FAIL pass_read got=%h/%h exp=08/d0000003", o_read_s, o_data_out);
        end
        i_conf_dbus = 5'h1E; i_start = 1'b1;
        tick();
        i_start = 1'b0; i_conf_dbus = '0;
        checks++;
        if (o_start_s !== 8'h08) begin failures++; $display("FAIL start_on_hub got=%h exp=08", o_start_s); end
        tick();
    endtask

    task automatic test_sel_timing();
        i_conf_dbus = 5'h1F; i_data_in = 32'd5; i_write = 1'b1; i_start = 1'b1;
        tick();
        i_write = 1'b0; i_start = 1'b0; i_conf_dbus = '0;
        checks++;
        if (o_start_s !== 8'h08 || o_write_s !== 8'h00) begin
            failures++;
            $display("FAIL sel_same_cycle got=%h/%h exp=08/00", o_start_s, o_write_s);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_start_s !== 8'h20) begin failures++; $display("FAIL sel_later got=%h exp=20", o_start_s); end
        tick();
    endtask

    task automatic test_sel_err();
        logic [DW-1:0] rd;
        hub_write(5'h1F, 32'd9);
        hub_read(5'h1C, rd);
        checks++;
        if (rd !== 32'h0000_0105) begin failures++; $display("FAIL sel_err_set got=%h exp=%h", rd, 32'h105); end
        hub_write(5'h1C, 32'h0);
        hub_read(5'h1C, rd);
        checks++;
        if (rd !== 32'h0000_0005) begin failures++; $display("FAIL sel_err_clear got=%h exp=%h", rd, 32'h5); end
    endtask

    task automatic test_irq_next();
        logic [DW-1:0] rd;
        hub_write(5'h1E, 32'hFF);
        i_int_s = 8'h24;
        tick();
        hub_read(5'h1D, rd);
        checks++;
        if (rd !== 32'h24) begin failures++; $display("FAIL irq_pend got=%h exp=%h", rd, 32'h24); end
        checks++;
        if (o_int_req !== 1'b1) begin failures++; $display("FAIL irq_req_high got=%b exp=1", o_int_req); end
        hub_read(5'h1B, rd);
        checks++;
        if (rd !== 32'h8000_0002) begin failures++; $display("FAIL next_first got=%h exp=%h", rd, 32'h80000002); end
        hub_read(5'h1F, rd);
        checks++;
        if (rd !== 32'h2) begin failures++; $display("FAIL next_sel got=%h exp=%h", rd, 32'h2); end
        hub_read(5'h1B, rd);
        checks++;
        if (rd !== 32'h8000_0005) begin failures++; $display("FAIL next_second got=%h exp=%h", rd, 32'h80000005); end
        hub_read(5'h1B, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL next_empty got=%h exp=%h", rd, 32'h0); end
        checks++;
        if (o_int_req !== 1'b0) begin failures++; $display("FAIL irq_req_low got=%b exp=0", o_int_req); end
        i_int_s = 8'h00;
        tick();
    endtask

    task automatic test_w1c_race();
        logic [DW-1:0] rd;
        i_int_s = 8'h10;
        hub_write(5'h1D, 32'h10);
        hub_read(5'h1D, rd);
        checks++;
        if (rd !== 32'h10) begin failures++; $display("FAIL w1c_set_wins got=%h exp=%h", rd, 32'h10); end
        hub_write(5'h1D, 32'hFFFF_FF10);
        hub_read(5'h1D, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", rd, 32'h0); end
    endtask

    task automatic test_wrap_and_mask();
        logic [DW-1:0] rd;
        // last served is 5; only slave 1 pending -> search wraps through 6,7,0,1
        i_int_s = 8'h12;
        tick();
        hub_read(5'h1B, rd);
        checks++;
        if (rd !== 32'h8000_0001) begin failures++; $display("FAIL next_wrap got=%h exp=%h", rd, 32'h80000001); end
        hub_write(5'h1E, 32'h00);
        i_int_s = 8'h13;
        tick(); tick();
        hub_read(5'h1D, rd);
        checks++;
        if (rd !== 32'h01) begin failures++; $display("FAIL masked_pend got=%h exp=%h", rd, 32'h1); end
        checks++;
        if (o_int_req !== 1'b0) begin failures++; $display("FAIL masked_req got=%b exp=0", o_int_req); end
        hub_read(5'h1B, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL masked_next got=%h exp=%h", rd, 32'h0); end
        hub_write(5'h1E, 32'h01);
        tick();
        checks++;
        if (o_int_req !== 1'b1) begin failures++; $display("FAIL unmask_req got=%b exp=1", o_int_req); end
        hub_write(5'h1D, 32'h01);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd;
        hub_write(5'h1F, 32'd6);
        i_conf_dbus = 5'h02; i_read = 1'b1;
        tick();
        checks++;
        if (o_read_s !== 8'h40 || o_data_out !== 32'hD000_0006) begin
            failures++;
            $display("FAIL mid_read got=%h/%h exp=40/d0000006", o_read_s, o_data_out);
        end
        #2;
        i_rst_a = 1'b1;
        #1;
        checks++;
        if (o_read_s !== 8'h00 || o_data_out !== 32'h0) begin
            failures++;
            $display("FAIL async_reset got=%h/%h exp=00/0", o_read_s, o_data_out);
        end
        i_read = 1'b0; i_conf_dbus = '0;
        tick();
        i_rst_a = 1'b0;
        tick(); tick();
        checks++;
        if (o_read_s !== 8'h00 || o_int_req !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got=%h/%b exp=00/0", o_read_s, o_int_req);
        end
        hub_read(5'h1F, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL post_reset_sel got=%h exp=%h", rd, 32'h0); end
        hub_read(5'h1E, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL post_reset_mask got=%h exp=%h", rd, 32'h0); end
        hub_read(5'h1D, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL high_line_no_pend got=%h exp=%h", rd, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_sel_timing();
        test_sel_err();
        test_irq_next();
        test_w1c_race();
        test_wrap_and_mask();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aip_slave_hub.md
AIP_SLAVE_HUB -- requirements
Module: aip_slave_hub

Interface
REQ-001 Parameters (name, default, meaning): NUM_SLAVES 8, AIP slave channels (1..16); DATA_WIDTH 32, data bus width; CONF_WIDTH 5, config bus width; SEL_W = max(1, clog2(NUM_SLAVES)), derived, not overridable.
REQ-002 Ports (name direction width meaning):
- i_clk  in  1  single clock
- i_rst_a  in  1  reset, asynchronous, active-high
- i_data_in  in  DATA_WIDTH  upstream write data
- o_data_out  out  DATA_WIDTH  upstream read data
- i_write / i_read / i_start  in  1 each  upstream strobes
- i_conf_dbus  in  CONF_WIDTH  upstream config address
- o_int_req  out  1  aggregated interrupt
- o_dataIn_s  out  NUM_SLAVES*DATA_WIDTH  per-slave write data, slice k = slave k
- o_config_s  out  NUM_SLAVES*CONF_WIDTH  per-slave config
- o_write_s / o_read_s / o_start_s  out  NUM_SLAVES each  per-slave strobes
- i_dataOut_s  in  NUM_SLAVES*DATA_WIDTH  per-slave read data
- i_int_s  in  NUM_SLAVES  per-slave interrupt level

Function
REQ-003 Hub registers by i_conf_dbus: 0x1F SEL (rw, SEL_W bits), 0x1E MASK (rw, NUM_SLAVES bits), 0x1D PEND (r, write-1-to-clear), 0x1C STATUS (r: [SEL_W-1:0]=sel, bit 8=sel_err sticky, bit 9=int_req; write any value clears sel_err), 0x1B NEXT (r, side effect per REQ-011). All other codes are pass-through.
REQ-004 Pass-through write/read/start: register slave sel's o_write_s/o_read_s/o_start_s bit one cycle after the upstream strobe; all other strobe bits stay 0.
REQ-005 o_dataIn_s and o_config_s: every slice registered from i_data_in / i_conf_dbus every cycle (broadcast); only strobes are steered.
REQ-006 Strobe routing uses the sel value at the cycle the upstream strobe is sampled; a SEL write in that same cycle affects only later strobes.
REQ-007 Hub-register accesses never produce downstream strobes; i_start is always forwarded, regardless of conf code.
REQ-008 o_data_out registered, 1-cycle latency: hub register value (zero-extended) when conf is a hub code, else i_dataOut_s slice [sel].
REQ-009 SEL write with value >= NUM_SLAVES: sel unchanged, sel_err set.
REQ-010 Interrupts: per-slave rising-edge detect on i_int_s (previous-level register); edge sets PEND[k]. A W1C of bit k in the same cycle as a set on k leaves PEND[k]=1 (set wins).
REQ-011 NEXT read: round-robin search of PEND&MASK starting at last_served+1 modulo NUM_SLAVES. If a hit exists: return {bit31=1, index in low SEL_W bits}, clear that PEND bit, load sel=index, update last_served=index, all effective the cycle after the read. If none: return 0, no state change. A NEXT read lasting N cycles acts once, on the rising edge of i_read.
REQ-012 o_int_req registered = |(PEND & MASK); 1-cycle latency after PEND/MASK change.
REQ-013 Unused high bits of hub reads = 0; writes to PEND/NEXT bits >= NUM_SLAVES ignored.

Reset
REQ-014 On i_rst_a high, asynchronously: sel=0, MASK=0, PEND=0, sel_err=0, last_served=NUM_SLAVES-1, edge registers=0, all outputs 0.
REQ-015 Reset mid-transfer drops any in-flight strobe; no strobe emitted after reset release without a new upstream strobe.
REQ-016 Interrupt lines high during reset release do not set PEND (edge history resets to 0 but the first sampled cycle only loads history).

Verification
REQ-017 Write SEL=3, pulse i_write with conf=0x02, data=0xA5A5A5A5 -> next cycle o_write_s=0x08, slice 3 conf=0x02, data=0xA5A5A5A5; other strobe bits 0.
REQ-018 SEL=9 with NUM_SLAVES=8 -> sel stays previous, STATUS bit8=1; STATUS write -> bit8=0.
REQ-019 MASK=0xFF; raise i_int_s[2] and [5] -> PEND=0x24, o_int_req=1; NEXT -> 0x80000002, sel=2; NEXT -> 0x80000005; NEXT -> 0x0, o_int_req=0.
REQ-020 PEND W1C of bit 4 in same cycle as rising edge on i_int_s[4] -> PEND[4]=1.
REQ-021 Assert i_rst_a mid-read on slave 6 -> o_read_s=0, o_data_out=0 immediately; after release, SEL=0, MASK=0, o_int_req=0.
